freq_meter: RTL and testbench

- Synchronous, gated multi-channel edge counter and frequency meter; parametrised successor to the asynchronous per-signal posedge counter.
- Each input is synchronised into the AXI clock domain and its rising edges are counted over a programmable window of reference-clock cycles.
- Results are snapshotted into a flattened output bus for AXI register readout.
- Supports single-shot and back-to-back continuous windows, abort, and saturation flags.

---
 rtl/freq_meter.sv | 163 ++++++++++++++++
 tb/tb_freq_meter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: synchronised multi-channel rising-edge counter over a gated
// window of axi_clk cycles, with single-shot/continuous modes and abort.
module freq_meter #(
  parameter int NUM_SIG     = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       axi_clk,
  input  logic                       axi_resetn,
  input  logic [NUM_SIG-1:0]         input_signals,
  input  logic [CNT_W-1:0]           gate_cycles,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       abort,
  output logic                       busy,
  output logic                       meas_valid,
  output logic [NUM_SIG*CNT_W-1:0]   meas_count,
  output logic [NUM_SIG-1:0]         meas_overflow,
  output logic [CNT_W-1:0]           window_count
);

  typedef enum logic {
    S_IDLE,
    S_MEAS
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_SIG-1:0] sync_q;
  logic [NUM_SIG-1:0] prev_q;
  logic [NUM_SIG-1:0] strobe;

  logic [CNT_W-1:0] gate_len_q;
  logic [CNT_W-1:0] gate_cnt_q;

  logic [NUM_SIG-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_SIG-1:0][CNT_W-1:0] cnt_d;
  logic [NUM_SIG-1:0]            ovf_q;
  logic [NUM_SIG-1:0]            ovf_d;

  logic [NUM_SIG-1:0][CNT_W-1:0] meas_cnt_q;
  logic [NUM_SIG-1:0]            meas_ovf_q;
  logic [CNT_W-1:0]              win_cnt_q;
  logic                          valid_q;

  logic in_meas;
  logic gate_nz;
  logic start_ok;
  logic win_last;
  logic win_done;
  logic restart;
  logic load;

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], input_signals};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

  assign in_meas  = (state_q == S_MEAS);
  assign gate_nz  = |gate_cycles;
  assign start_ok = !in_meas && start && gate_nz;
  assign win_last = in_meas && (gate_cnt_q == gate_len_q - ONE);
  assign win_done = win_last && !abort;
  assign restart  = win_done && continuous && gate_nz;
  assign load     = start_ok || restart;

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_MEAS;
      end
      S_MEAS: begin
        if (abort || (win_last && !restart)) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == S_MEAS);
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      gate_len_q <= '0;
      gate_cnt_q <= '0;
    end else if (load) begin
      gate_len_q <= gate_cycles;
      gate_cnt_q <= '0;
    end else if (in_meas) begin
      gate_cnt_q <= gate_cnt_q + ONE;
    end
  end

  // A strobe arriving while a counter is pinned at all-ones is a lost edge.
  always_comb begin
    cnt_d = '0;
    ovf_d = '0;
    for (int i = 0; i < NUM_SIG; i++) begin
      if (&cnt_q[i]) begin
        cnt_d[i] = cnt_q[i];
        ovf_d[i] = ovf_q[i] | strobe[i];
      end else begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, strobe[i]};
        ovf_d[i] = ovf_q[i];
      end
    end
  end

  // The closing cycle's strobe belongs to the finished window, so a
  // back-to-back window starts from zero and no edge is seen twice.
  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else if (in_meas) begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      meas_cnt_q <= '0;
      meas_ovf_q <= '0;
      win_cnt_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= win_done;
      if (win_done) begin
        meas_cnt_q <= cnt_d;
        meas_ovf_q <= ovf_d;
        win_cnt_q  <= win_cnt_q + ONE;
      end
    end
  end

  assign meas_valid    = valid_q;
  assign meas_count    = meas_cnt_q;
  assign meas_overflow = meas_ovf_q;
  assign window_count  = win_cnt_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: random and directed stimulus against a cycle-level
// behavioural model, plus literal checks on the directed scenarios.
module tb_freq_meter;

  localparam int NS   = 4;
  localparam int W    = 10;
  localparam int SS   = 2;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NS-1:0] sig;
  logic [W-1:0] gate;
  logic start, cont, abrt;
  logic busy, mvalid;
  logic [NS*W-1:0] mcount;
  logic [NS-1:0] movf;
  logic [W-1:0] wcount;

  always #5 clk = ~clk;

  freq_meter #(.NUM_SIG(NS), .CNT_W(W), .SYNC_STAGES(SS)) dut (
    .axi_clk(clk),
    .axi_resetn(rst_n),
    .input_signals(sig),
    .gate_cycles(gate),
    .start(start),
    .continuous(cont),
    .abort(abrt),
    .busy(busy),
    .meas_valid(mvalid),
    .meas_count(mcount),
    .meas_overflow(movf),
    .window_count(wcount)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mode [NS];
  int per [NS];
  int ph = 0;

  // Reference model: input samples per edge, edges seen SS cycles later,
  // and a window described as "cycles left" with a running edge tally.
  logic [NS-1:0] hist [0:SS];
  bit m_busy = 0;
  int m_left = 0;
  int m_edges [NS];
  logic exp_busy = 0, exp_valid = 0;
  logic [NS-1:0][W-1:0] exp_cnt = '0;
  logic [NS-1:0] exp_ovf = '0;
  logic [W-1:0] exp_wc = '0;

  always @(posedge clk) begin
    logic [NS-1:0] stb;
    cyc++;
    if (!rst_n) begin
      for (int j = 0; j <= SS; j++) hist[j] = '0;
      m_busy = 0;
      m_left = 0;
      exp_busy = 0;
      exp_valid = 0;
      exp_cnt = '0;
      exp_ovf = '0;
      exp_wc = '0;
    end else begin
      stb = hist[SS-1] & ~hist[SS];
      exp_valid = 0;
      if (m_busy) begin
        for (int c = 0; c < NS; c++) m_edges[c] += int'(stb[c]);
        if (abrt) begin
          m_busy = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            for (int c = 0; c < NS; c++) begin
              exp_cnt[c] = W'((m_edges[c] > MAXC) ? MAXC : m_edges[c]);
              exp_ovf[c] = (m_edges[c] > MAXC);
            end
            exp_wc = exp_wc + 1'b1;
            exp_valid = 1;
            if (cont && gate != 0) begin
              m_left = int'(gate);
              for (int c = 0; c < NS; c++) m_edges[c] = 0;
            end else begin
              m_busy = 0;
            end
          end
        end
      end else if (start && gate != 0) begin
        m_busy = 1;
        m_left = int'(gate);
        for (int c = 0; c < NS; c++) m_edges[c] = 0;
      end
      exp_busy = m_busy;
      for (int j = SS; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = sig;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      tests++;
      if (busy !== exp_busy || mvalid !== exp_valid || mcount !== exp_cnt ||
          movf !== exp_ovf || wcount !== exp_wc) begin
        fails++;
        if (fails <= 20)
          $display("FAIL model cyc %0d: got busy=%b valid=%b cnt=%h ovf=%b wc=%0d want busy=%b valid=%b cnt=%h ovf=%b wc=%0d",
                   cyc, busy, mvalid, mcount, movf, wcount,
                   exp_busy, exp_valid, exp_cnt, exp_ovf, exp_wc);
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_rng(input string nm, input longint got,
                         input longint lo, input longint hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NS; c++) begin
      case (mode[c])
        0: sig[c] = 1'b0;
        1: sig[c] = 1'b1;
        2: sig[c] = ((ph % per[c]) < per[c] / 2);
        default: sig[c] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    drive_inputs();
  endtask

  logic [W-1:0] sn_cnt [NS];
  logic [NS-1:0] sn_ovf;
  logic [W-1:0] sn_wc;
  int nv, lat, nb, n, k, sum, t0, len;
  int vt [5];
  int wv [5];

  task automatic window(input int g, input int budget);
    int ts;
    nv = 0;
    lat = -1;
    nb = 0;
    gate = W'(g);
    start = 1;
    tick();
    start = 0;
    ts = cyc;
    if (busy) nb++;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy) nb++;
      if (mvalid) begin
        nv++;
        if (lat < 0) begin
          lat = cyc - ts;
          for (int c = 0; c < NS; c++) sn_cnt[c] = mcount[c*W +: W];
          sn_ovf = movf;
          sn_wc = wcount;
        end
      end
    end
  endtask

  task automatic count_valids(input int budget);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mvalid) n++;
    end
  endtask

  initial begin
    rst_n = 0; sig = '0; gate = '0; start = 0; cont = 0; abrt = 0;
    for (int c = 0; c < NS; c++) begin
      mode[c] = 3;
      per[c] = 2;
    end
    gate = 50;
    start = 1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", mvalid, 0);
    chk("rst_count", mcount, 0);
    chk("rst_ovf", movf, 0);
    chk("rst_wc", wcount, 0);
    rst_n = 1;
    start = 0;
    tick();
    chk("rst_start_ignored", busy, 0);

    mode[0] = 2; per[0] = 10;
    mode[1] = 1;
    mode[2] = 2; per[2] = 2;
    mode[3] = 0;
    repeat (10) tick();
    window(1000, 1100);
    chk("ss_valids", nv, 1);
    chk("ss_latency", lat, 1000);
    chk("ss_busy_cycles", nb, 1000);
    chk_rng("ss_ch0", sn_cnt[0], 99, 101);
    chk("ss_ch1", sn_cnt[1], 0);
    chk("ss_ch2", sn_cnt[2], 500);
    chk("ss_ch3", sn_cnt[3], 0);
    chk("ss_ovf", sn_ovf, 0);
    chk("ss_wc", sn_wc, 1);

    mode[0] = 2; per[0] = 2;
    mode[1] = 2; per[1] = 10;
    mode[2] = 0;
    mode[3] = 3;
    repeat (5) tick();
    window(1023, 1100);
    chk_rng("long_ch0", sn_cnt[0], 511, 512);
    chk_rng("long_ch1", sn_cnt[1], 102, 103);
    chk("long_ovf01", sn_ovf[1:0], 0);
    per[0] = 10;
    repeat (5) tick();
    window(1000, 1100);
    chk("second_ch0", sn_cnt[0], 100);
    chk("second_ovf0", sn_ovf[0], 0);

    mode[0] = 2; per[0] = 4;
    mode[1] = 3;
    mode[2] = 2; per[2] = 6;
    mode[3] = 1;
    repeat (8) tick();
    gate = 100;
    cont = 1;
    start = 1;
    tick();
    start = 0;
    t0 = cyc;
    k = 0;
    sum = 0;
    for (int i = 0; i < 600 && k < 5; i++) begin
      tick();
      if (mvalid) begin
        vt[k] = cyc;
        wv[k] = int'(wcount);
        sum += int'(mcount[W-1:0]);
        k++;
      end
    end
    chk("cont_windows", k, 5);
    chk("cont_first", vt[0] - t0, 100);
    for (int j = 1; j < 5; j++) begin
      chk("cont_period", vt[j] - vt[j-1], 100);
      chk("cont_wc_step", wv[j] - wv[j-1], 1);
    end
    chk_rng("cont_sum", sum, 124, 126);
    repeat (50) tick();
    cont = 0;
    count_valids(200);
    chk("cont_stop_valids", n, 1);
    chk("cont_stop_idle", busy, 0);

    gate = 200;
    start = 1;
    tick();
    start = 0;
    repeat (49) tick();
    abrt = 1;
    tick();
    abrt = 0;
    chk("abort_busy", busy, 0);
    count_valids(300);
    chk("abort_no_valid", n, 0);

    gate = 30;
    start = 1;
    abrt = 1;
    tick();
    start = 0;
    abrt = 0;
    chk("idle_abort_start", busy, 1);
    count_valids(40);
    chk("idle_abort_valids", n, 1);

    gate = 0;
    start = 1;
    tick();
    start = 0;
    chk("zero_gate_busy", busy, 0);
    repeat (5) tick();
    chk("zero_gate_idle", busy, 0);

    window(20, 30);
    chk("short_latency", lat, 20);
    gate = 20;
    start = 1;
    tick();
    start = 0;
    repeat (19) tick();
    abrt = 1;
    tick();
    abrt = 0;
    chk("abort_last_busy", busy, 0);
    count_valids(10);
    chk("abort_last_valids", n, 0);

    gate = 200;
    start = 1;
    tick();
    start = 0;
    repeat (39) tick();
    rst_n = 0;
    tick();
    chk("midrst_wc", wcount, 0);
    chk("midrst_count", mcount, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1;
    repeat (4) tick();
    window(100, 120);
    chk("fresh_valids", nv, 1);
    chk("fresh_latency", lat, 100);
    chk("fresh_wc", sn_wc, 1);

    gate = 1;
    cont = 1;
    start = 1;
    tick();
    start = 0;
    count_valids(1030);
    cont = 0;
    repeat (4) tick();
    chk("wrap_valids", n, 1030);
    chk("wrap_wc", wcount, 8);

    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < NS; c++) begin
        mode[c] = $urandom_range(0, 3);
        per[c] = $urandom_range(2, 20);
      end
      gate = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 150));
      cont = 1'($urandom_range(0, 1));
      start = 1;
      tick();
      start = 0;
      len = $urandom_range(20, 400);
      for (int i = 0; i < len; i++) begin
        abrt = ($urandom_range(0, 199) == 0);
        start = ($urandom_range(0, 49) == 0);
        rst_n = !($urandom_range(0, 999) == 0);
        if ($urandom_range(0, 63) == 0) cont = ~cont;
        if ($urandom_range(0, 31) == 0) gate = W'($urandom_range(0, 150));
        tick();
      end
      abrt = 0;
      start = 0;
      rst_n = 1;
    end
    cont = 0;
    repeat (400) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
